pool_ctrl: RTL and testbench
============================

Name: pool_ctrl

Overview:
- Sequencer for the max-pool layer datapath: per-channel sliding-window input buffers feeding a combinational per-channel max.
- Accepts one pixel per handshake from the previous layer and broadcasts the write enable to every channel buffer.
- Tracks row/column position in the frame, detects stride-aligned complete windows, and hands each pooled result to the next layer under its busy handshake.

Parameters:
- img_width, 28, input image width/height (square frame, pixels per row).
- kernel_dim, 2, pooling window dimension K (KxK window).
- stride, 2, window step in both directions; 1 <= stride <= kernel_dim.
- Derived, not overridable:
  - out_dim = (img_width - kernel_dim)/stride + 1
  - cw = $clog2(img_width)
  - ow = $clog2(out_dim), minimum 1

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_start  input  1  frame start pulse; honoured only in IDLE.
- i_prev_valid  input  1  previous layer presents a pixel (all channels).
- o_busy  output  1  high = pixel not accepted this cycle.
- o_ibuf_we  output  1  broadcast write enable to all channel input buffers.
- o_func_start  output  1  pooled window valid; pool outputs stable while high.
- i_next_busy  input  1  next layer cannot take a result.
- o_next_start  output  1  one-cycle pulse: next layer captures pooled data.
- o_out_row  output  ow  output-map row of current/last emitted result.
- o_out_col  output  ow  output-map column of current/last emitted result.
- o_done  output  1  one-cycle pulse after final pixel/result of frame.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; row/col counters = 0; o_out_row/o_out_col = 0.
  - o_busy = 1; o_ibuf_we, o_func_start, o_next_start, o_done = 0.
  - Reset mid-frame abandons the frame; no o_done is issued.
- States: IDLE, LOAD, WAIT, EMIT, DONE.
- IDLE:
  - o_busy = 1.
  - i_start -> LOAD; counters cleared.
- LOAD:
  - o_busy = 0.
  - Accept = i_prev_valid & ~o_busy; o_ibuf_we = accept, combinational, same cycle. No write in any other state.
  - On accept at (row, col), the position advances in raster order: col wraps at img_width-1 and increments row.
  - Window complete when all hold:
    - row >= K-1 and col >= K-1
    - (row-(K-1)) % stride == 0
    - (col-(K-1)) % stride == 0
    - (col-(K-1))/stride < out_dim and (row-(K-1))/stride < out_dim
  - Window complete -> WAIT. o_out_row/o_out_col load the window indices in the same edge.
  - Trailing pixels beyond the last window are consumed without emit.
  - Accepting the last pixel (img_width-1, img_width-1) with no window -> DONE.
- WAIT:
  - o_busy = 1; o_func_start = 1, which gives the buffers one cycle to present the new window.
  - ~i_next_busy -> EMIT. Otherwise hold indefinitely.
- EMIT:
  - o_func_start = 1, o_next_start = 1, for exactly one cycle.
  - -> DONE if the frame's last pixel was already accepted, else -> LOAD.
- DONE: o_done = 1 for one cycle -> IDLE.
- All outputs except o_ibuf_we are registered state decodes.
- Latency: completing pixel accepted at edge t -> WAIT at t+1 -> earliest o_next_start at t+2 -> LOAD at t+3.
- i_start outside IDLE is ignored. i_prev_valid outside LOAD is ignored, with no write.
- i_next_busy is sampled only in WAIT; toggling it elsewhere has no effect.

Optional Feature:
- Macro: POOL_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cycles, 16 bits.
  - Increments on every cycle in WAIT with i_next_busy = 1; saturates at 16'hFFFF.
  - Cleared by reset and by an accepted i_start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- W=4, K=2, S=2, i_prev_valid always 1, i_next_busy=0:
  - Exactly 4 o_next_start pulses, after pixel indices 5, 7, 13, 15, with (row,col) = (0,0), (0,1), (1,0), (1,1).
  - o_done one cycle after the pulse for pixel 15.
  - 16 o_ibuf_we cycles total.
- W=4, K=2, S=1:
  - 9 o_next_start pulses, first after pixel index 5.
  - o_out_col sequence 0,1,2 per row.
  - o_done once.
- W=5, K=2, S=2:
  - 4 results only; pixels in row 4 and column 4 produce no emit.
  - o_done after pixel 24 with no preceding emit.
- Backpressure: i_next_busy=1 held 5 cycles when WAIT is entered:
  - o_busy=1 and o_ibuf_we=0 throughout; o_func_start held.
  - o_next_start pulses 1 cycle after i_next_busy falls.
  - With the macro: o_stall_cycles = 5.
- rst low for 1 cycle after 6 pixels:
  - All outputs return to reset values immediately; no o_done.
  - A new i_start produces a clean 4-result frame.
- i_start pulsed during LOAD and WAIT:
  - No effect on counters or state.

Source files
------------

// File: rtl/pool_ctrl.sv
// ---------------------------------------------------------------------------
// pool_ctrl
//   Sequencer for the max-pool layer. Accepts one pixel per handshake from
//   the previous layer and broadcasts the write enable to every per-channel
//   sliding-window buffer. It tracks the raster position in the frame and,
//   for each stride-aligned complete window, holds the pooled result stable
//   until the next layer can take it.
//
// Optional build macro: POOL_CTRL_STALL_CNT_EN
//   When defined, adds o_stall_cycles: a saturating count of the cycles spent
//   waiting on i_next_busy. It is cleared by reset and by an accepted i_start.
//
// Ports
//   clk             clock, all state on the rising edge
//   rst             asynchronous active-low reset
//   i_start         frame start pulse, honoured only in IDLE
//   i_prev_valid    previous layer presents a pixel (all channels)
//   o_busy          high = pixel not accepted this cycle
//   o_ibuf_we       broadcast write enable to the channel input buffers
//   o_func_start    pooled window valid; pool outputs stable while high
//   i_next_busy     next layer cannot take a result
//   o_next_start    one-cycle pulse: next layer captures the pooled data
//   o_out_row/col   output-map position of the current/last emitted result
//   o_done          one-cycle pulse at the end of the frame
//   o_stall_cycles  (macro only) backpressure cycle count, 16 bits
//
// States
//   state | meaning
//   IDLE  | waiting for i_start, input side busy
//   LOAD  | accepting pixels, watching for a complete window
//   WAIT  | window presented, waiting for the next layer to be free
//   EMIT  | o_next_start pulse, the next layer captures the result
//   DONE  | o_done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module pool_ctrl #(
    parameter int img_width  = 28,
    parameter int kernel_dim = 2,
    parameter int stride     = 2,
    localparam int out_dim   = (img_width - kernel_dim) / stride + 1,
    localparam int ow        = (out_dim > 1) ? $clog2(out_dim) : 1,
    localparam int cw        = (img_width > 1) ? $clog2(img_width) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_prev_valid,
    output logic          o_busy,
    output logic          o_ibuf_we,
    output logic          o_func_start,
    input  logic          i_next_busy,
    output logic          o_next_start,
    output logic [ow-1:0] o_out_row,
    output logic [ow-1:0] o_out_col,
    output logic          o_done
`ifdef POOL_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   o_stall_cycles
`endif
);

    localparam logic [cw-1:0] LAST_IDX = cw'(img_width - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, EMIT, DONE} state_t;

    state_t        state_q;
    logic [cw-1:0] row_q;
    logic [cw-1:0] col_q;
    logic          last_q;
    logic          busy_q;
    logic          func_start_q;
    logic          next_start_q;
    logic          done_q;
    logic [ow-1:0] out_row_q;
    logic [ow-1:0] out_col_q;

    logic          accept;
    logic          at_row_end;
    logic          at_last;
    logic          win_hit;
    logic [ow-1:0] win_row;
    logic [ow-1:0] win_col;
    int            row_rel;
    int            col_rel;

    // busy_q is only low in LOAD; the state term keeps the write strictly
    // confined to LOAD even if that relationship is ever changed.
    assign accept     = i_prev_valid & ~busy_q & (state_q == LOAD);
    assign at_row_end = (col_q == LAST_IDX);
    assign at_last    = at_row_end && (row_q == LAST_IDX);

    // Window check on the position of the pixel being accepted: the window
    // whose bottom-right corner sits here is complete when it lies on the
    // stride grid and inside the output map.
    always_comb begin
        row_rel = int'(row_q) - (kernel_dim - 1);
        col_rel = int'(col_q) - (kernel_dim - 1);
        win_hit = 1'b0;
        win_row = '0;
        win_col = '0;
        if ((row_rel >= 0) && (col_rel >= 0) &&
            ((row_rel % stride) == 0) && ((col_rel % stride) == 0) &&
            ((row_rel / stride) < out_dim) && ((col_rel / stride) < out_dim)) begin
            win_hit = 1'b1;
            win_row = ow'(row_rel / stride);
            win_col = ow'(col_rel / stride);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b1;
            func_start_q <= 1'b0;
            next_start_q <= 1'b0;
            done_q       <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            next_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= LOAD;
                        row_q   <= '0;
                        col_q   <= '0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        last_q <= at_last;
                        if (at_row_end) begin
                            col_q <= '0;
                            if (!at_last) begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (win_hit) begin
                            state_q      <= WAIT;
                            busy_q       <= 1'b1;
                            func_start_q <= 1'b1;
                            out_row_q    <= win_row;
                            out_col_q    <= win_col;
                        end else if (at_last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!i_next_busy) begin
                        state_q      <= EMIT;
                        next_start_q <= 1'b1;
                    end
                end
                EMIT: begin
                    func_start_q <= 1'b0;
                    if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b1;
                    func_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_ibuf_we    = accept;
    assign o_func_start = func_start_q;
    assign o_next_start = next_start_q;
    assign o_out_row    = out_row_q;
    assign o_out_col    = out_col_q;
    assign o_done       = done_q;

`ifdef POOL_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && i_start) begin
            stall_q <= '0;
        end else if ((state_q == WAIT) && i_next_busy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
module tb_pool_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0;
    logic i_prev_valid = 1'b0;
    logic i_next_busy = 1'b0;

    always #5 clk = ~clk;

    // dut_a: W=4 K=2 S=2, dut_b: W=4 K=2 S=1, dut_c: W=5 K=2 S=2
    logic       a_busy, a_we, a_fs, a_ns, a_done;
    logic [0:0] a_row, a_col;
    logic       b_busy, b_we, b_fs, b_ns, b_done;
    logic [1:0] b_row, b_col;
    logic       c_busy, c_we, c_fs, c_ns, c_done;
    logic [0:0] c_row, c_col;
`ifdef POOL_CTRL_STALL_CNT_EN
    logic [15:0] a_stall, b_stall, c_stall;
`endif

    pool_ctrl #(.img_width(4), .kernel_dim(2), .stride(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_prev_valid(i_prev_valid),
        .o_busy(a_busy), .o_ibuf_we(a_we), .o_func_start(a_fs),
        .i_next_busy(i_next_busy), .o_next_start(a_ns),
        .o_out_row(a_row), .o_out_col(a_col), .o_done(a_done)
`ifdef POOL_CTRL_STALL_CNT_EN
        , .o_stall_cycles(a_stall)
`endif
    );

    pool_ctrl #(.img_width(4), .kernel_dim(2), .stride(1)) dut_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_prev_valid(i_prev_valid),
        .o_busy(b_busy), .o_ibuf_we(b_we), .o_func_start(b_fs),
        .i_next_busy(i_next_busy), .o_next_start(b_ns),
        .o_out_row(b_row), .o_out_col(b_col), .o_done(b_done)
`ifdef POOL_CTRL_STALL_CNT_EN
        , .o_stall_cycles(b_stall)
`endif
    );

    pool_ctrl #(.img_width(5), .kernel_dim(2), .stride(2)) dut_c (
        .clk(clk), .rst(rst), .i_start(i_start), .i_prev_valid(i_prev_valid),
        .o_busy(c_busy), .o_ibuf_we(c_we), .o_func_start(c_fs),
        .i_next_busy(i_next_busy), .o_next_start(c_ns),
        .o_out_row(c_row), .o_out_col(c_col), .o_done(c_done)
`ifdef POOL_CTRL_STALL_CNT_EN
        , .o_stall_cycles(c_stall)
`endif
    );

    int   sel = 0;
    logic mon_busy, mon_we, mon_fs, mon_ns, mon_done;
    int   mon_row, mon_col;

    always_comb begin
        mon_busy = a_busy; mon_we = a_we; mon_fs = a_fs; mon_ns = a_ns; mon_done = a_done;
        mon_row = int'(a_row); mon_col = int'(a_col);
        case (sel)
            1: begin
                mon_busy = b_busy; mon_we = b_we; mon_fs = b_fs; mon_ns = b_ns; mon_done = b_done;
                mon_row = int'(b_row); mon_col = int'(b_col);
            end
            2: begin
                mon_busy = c_busy; mon_we = c_we; mon_fs = c_fs; mon_ns = c_ns; mon_done = c_done;
                mon_row = int'(c_row); mon_col = int'(c_col);
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    int ns_cnt, we_cnt, done_cnt, last_ns_cyc, done_cyc, done_pix;
    int ns_pix[16];
    int ns_row[16];
    int ns_col[16];

    task automatic do_reset();
        rst = 1'b0;
        i_start = 1'b0;
        i_prev_valid = 1'b0;
        i_next_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one frame with i_prev_valid held high and records what the
    // selected DUT emits. inject pulses i_start once in LOAD and once in WAIT.
    task automatic run_frame(input int s, input bit inject);
        bit seen_done = 1'b0;
        bit inj_l = 1'b0;
        bit inj_w = 1'b0;
        int post = 0;
        sel = s;
        ns_cnt = 0; we_cnt = 0; done_cnt = 0;
        last_ns_cyc = -100; done_cyc = -1; done_pix = -1;
        i_prev_valid = 1'b1;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int cyc = 0; cyc < 300 && post < 4; cyc++) begin
            @(negedge clk);
            if (mon_we) we_cnt++;
            if (mon_ns) begin
                if (ns_cnt < 16) begin
                    ns_pix[ns_cnt] = we_cnt - 1;
                    ns_row[ns_cnt] = mon_row;
                    ns_col[ns_cnt] = mon_col;
                end
                ns_cnt++;
                last_ns_cyc = cyc;
            end
            if (mon_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_pix = we_cnt - 1;
                seen_done = 1'b1;
            end
            if (seen_done) post++;
            if (inject) begin
                i_start = 1'b0;
                if (!inj_l && mon_we && we_cnt == 3) begin
                    i_start = 1'b1;
                    inj_l = 1'b1;
                end else if (!inj_w && mon_fs && !mon_ns) begin
                    i_start = 1'b1;
                    inj_w = 1'b1;
                end
            end
        end
        i_start = 1'b0;
        i_prev_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", a_busy); end
        n_cmp++; if (a_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", a_we); end
        n_cmp++; if (a_fs !== 1'b0) begin n_bad++; $display("FAIL reset_func_start got %b want 0", a_fs); end
        n_cmp++; if (a_ns !== 1'b0) begin n_bad++; $display("FAIL reset_next_start got %b want 0", a_ns); end
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", a_done); end
        n_cmp++; if ({b_row, b_col} !== 4'b0) begin n_bad++; $display("FAIL reset_rowcol got %b want 0000", {b_row, b_col}); end
        // prev_valid in IDLE must not write
        i_prev_valid = 1'b1;
        #1;
        n_cmp++; if (a_we !== 1'b0) begin n_bad++; $display("FAIL idle_we got %b want 0", a_we); end
        do_reset();
        n_cmp++; if (c_busy !== 1'b1) begin n_bad++; $display("FAIL idle_busy got %b want 1", c_busy); end
    endtask

    task automatic test_frame_s2();
        int ep[4] = '{5, 7, 13, 15};
        int er[4] = '{0, 0, 1, 1};
        int ec[4] = '{0, 1, 0, 1};
        do_reset();
        run_frame(0, 1'b0);
        n_cmp++; if (ns_cnt !== 4) begin n_bad++; $display("FAIL s2_ns_count got %0d want 4", ns_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ns_pix[i] !== ep[i]) begin n_bad++; $display("FAIL s2_pix[%0d] got %0d want %0d", i, ns_pix[i], ep[i]); end
            n_cmp++; if (ns_row[i] !== er[i] || ns_col[i] !== ec[i]) begin
                n_bad++; $display("FAIL s2_pos[%0d] got (%0d,%0d) want (%0d,%0d)", i, ns_row[i], ns_col[i], er[i], ec[i]);
            end
        end
        n_cmp++; if (we_cnt !== 16) begin n_bad++; $display("FAIL s2_we_count got %0d want 16", we_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL s2_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc - last_ns_cyc !== 1) begin n_bad++; $display("FAIL s2_done_gap got %0d want 1", done_cyc - last_ns_cyc); end
    endtask

    task automatic test_frame_s1();
        int ep[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        do_reset();
        run_frame(1, 1'b0);
        n_cmp++; if (ns_cnt !== 9) begin n_bad++; $display("FAIL s1_ns_count got %0d want 9", ns_cnt); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (ns_pix[i] !== ep[i]) begin n_bad++; $display("FAIL s1_pix[%0d] got %0d want %0d", i, ns_pix[i], ep[i]); end
            n_cmp++; if (ns_row[i] !== i / 3 || ns_col[i] !== i % 3) begin
                n_bad++; $display("FAIL s1_pos[%0d] got (%0d,%0d) want (%0d,%0d)", i, ns_row[i], ns_col[i], i / 3, i % 3);
            end
        end
        n_cmp++; if (we_cnt !== 16) begin n_bad++; $display("FAIL s1_we_count got %0d want 16", we_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL s1_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_frame_w5();
        int ep[4] = '{6, 8, 16, 18};
        int er[4] = '{0, 0, 1, 1};
        int ec[4] = '{0, 1, 0, 1};
        do_reset();
        run_frame(2, 1'b0);
        n_cmp++; if (ns_cnt !== 4) begin n_bad++; $display("FAIL w5_ns_count got %0d want 4", ns_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ns_pix[i] !== ep[i]) begin n_bad++; $display("FAIL w5_pix[%0d] got %0d want %0d", i, ns_pix[i], ep[i]); end
            n_cmp++; if (ns_row[i] !== er[i] || ns_col[i] !== ec[i]) begin
                n_bad++; $display("FAIL w5_pos[%0d] got (%0d,%0d) want (%0d,%0d)", i, ns_row[i], ns_col[i], er[i], ec[i]);
            end
        end
        n_cmp++; if (we_cnt !== 25) begin n_bad++; $display("FAIL w5_we_count got %0d want 25", we_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL w5_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (done_pix !== 24) begin n_bad++; $display("FAIL w5_done_pix got %0d want 24", done_pix); end
        n_cmp++; if ((done_cyc - last_ns_cyc > 1) !== 1'b1) begin
            n_bad++; $display("FAIL w5_done_no_emit gap got %0d want >1", done_cyc - last_ns_cyc);
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        bit got_done = 1'b0;
        do_reset();
        sel = 0;
        i_next_busy = 1'b1;
        i_prev_valid = 1'b1;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (a_fs) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL bp_wait_entry got %b want 1", found); end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++; if ({a_busy, a_we, a_fs, a_ns} !== 4'b1010) begin
                n_bad++; $display("FAIL bp_hold[%0d] busy/we/fs/ns got %b want 1010", k, {a_busy, a_we, a_fs, a_ns});
            end
        end
        i_next_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if ({a_fs, a_ns} !== 2'b11) begin n_bad++; $display("FAIL bp_release fs/ns got %b want 11", {a_fs, a_ns}); end
        n_cmp++; if ({a_row, a_col} !== 2'b00) begin n_bad++; $display("FAIL bp_pos got %b want 00", {a_row, a_col}); end
`ifdef POOL_CTRL_STALL_CNT_EN
        n_cmp++; if (a_stall !== 16'd5) begin n_bad++; $display("FAIL bp_stall_cycles got %0d want 5", a_stall); end
`endif
        @(negedge clk);
        n_cmp++; if (a_ns !== 1'b0) begin n_bad++; $display("FAIL bp_ns_one_cycle got %b want 0", a_ns); end
        for (int k = 0; k < 100 && !got_done; k++) begin
            @(negedge clk);
            if (a_done) got_done = 1'b1;
        end
        n_cmp++; if (got_done !== 1'b1) begin n_bad++; $display("FAIL bp_frame_done got %b want 1", got_done); end
        i_prev_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        int dn = 0;
        int ep[4] = '{5, 7, 13, 15};
        do_reset();
        sel = 0;
        i_prev_valid = 1'b1;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 0; k < 50 && cnt < 6; k++) begin
            @(negedge clk);
            if (a_we) cnt++;
        end
        n_cmp++; if (cnt !== 6) begin n_bad++; $display("FAIL rm_pixels got %0d want 6", cnt); end
        @(posedge clk); #1;
        n_cmp++; if (a_fs !== 1'b1) begin n_bad++; $display("FAIL rm_in_wait fs got %b want 1", a_fs); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({a_busy, a_we, a_fs, a_ns, a_done} !== 5'b10000) begin
            n_bad++; $display("FAIL rm_async busy/we/fs/ns/done got %b want 10000", {a_busy, a_we, a_fs, a_ns, a_done});
        end
        n_cmp++; if ({a_row, a_col} !== 2'b00) begin n_bad++; $display("FAIL rm_async_pos got %b want 00", {a_row, a_col}); end
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_done) dn++;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rm_no_done got %0d want 0", dn); end
        i_prev_valid = 1'b0;
        run_frame(0, 1'b0);
        n_cmp++; if (ns_cnt !== 4) begin n_bad++; $display("FAIL rm_ns_count got %0d want 4", ns_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ns_pix[i] !== ep[i]) begin n_bad++; $display("FAIL rm_pix[%0d] got %0d want %0d", i, ns_pix[i], ep[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rm_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        int ep[4] = '{5, 7, 13, 15};
        int er[4] = '{0, 0, 1, 1};
        int ec[4] = '{0, 1, 0, 1};
        do_reset();
        run_frame(0, 1'b1);
        n_cmp++; if (ns_cnt !== 4) begin n_bad++; $display("FAIL si_ns_count got %0d want 4", ns_cnt); end
        n_cmp++; if (we_cnt !== 16) begin n_bad++; $display("FAIL si_we_count got %0d want 16", we_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ns_pix[i] !== ep[i] || ns_row[i] !== er[i] || ns_col[i] !== ec[i]) begin
                n_bad++; $display("FAIL si_result[%0d] got pix %0d (%0d,%0d) want pix %0d (%0d,%0d)",
                                  i, ns_pix[i], ns_row[i], ns_col[i], ep[i], er[i], ec[i]);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL si_done_count got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame_s2();
        test_frame_s1();
        test_frame_w5();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
